// File: rtl/alu_operand_sequencer_if.sv
// Operand bus from the sequencer to the combinational ALU and its operation units.
// Handshake: operands_valid is a level qualifier with no ready; a, b and op are stable whenever it is high.
interface alu_operand_sequencer_if #(
  parameter int width = 4,
  parameter int opw   = 4
);
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic [opw-1:0]   op;
  logic             operands_valid;

  modport master (
    output a,
    output b,
    output op,
    output operands_valid
  );

  modport slave (
    input a,
    input b,
    input op,
    input operands_valid
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Button-stepped loader for ALU operands: synchronizes and edge-detects two raw buttons,
// captures A, B and opcode from the switch bank, and counts executed operations.
module alu_operand_sequencer #(
  parameter int width = 4,
  parameter int opw   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_next,
  input  logic                 btn_clear,
  input  logic [width-1:0]     sw,
  alu_operand_sequencer_if.master alu_bus,
  output logic [1:0]           state,
  output logic [7:0]           op_count
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    EXEC    = 2'b11
  } state_e;

  // Button synchronizers and edge detectors
  logic next_s1_q, next_s1_d;
  logic next_s2_q, next_s2_d;
  logic next_prev_q, next_prev_d;
  logic clear_s1_q, clear_s1_d;
  logic clear_s2_q, clear_s2_d;
  logic clear_prev_q, clear_prev_d;
  logic next_ev;
  logic clear_ev;

  // Sequencer state and operand registers
  state_e           state_q, state_d;
  logic [width-1:0] a_q, a_d;
  logic [width-1:0] b_q, b_d;
  logic [opw-1:0]   op_q, op_d;
  logic [7:0]       op_count_q, op_count_d;

  always_comb begin
    next_s1_d    = btn_next;
    next_s2_d    = next_s1_q;
    next_prev_d  = next_s2_q;
    clear_s1_d   = btn_clear;
    clear_s2_d   = clear_s1_q;
    clear_prev_d = clear_s2_q;
  end

  assign next_ev  = next_s2_q & ~next_prev_q;
  assign clear_ev = clear_s2_q & ~clear_prev_q;

  // Reset to 1 so a button held through reset release reads as already pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_s1_q    <= 1'b1;
      next_s2_q    <= 1'b1;
      next_prev_q  <= 1'b1;
      clear_s1_q   <= 1'b1;
      clear_s2_q   <= 1'b1;
      clear_prev_q <= 1'b1;
    end else begin
      next_s1_q    <= next_s1_d;
      next_s2_q    <= next_s2_d;
      next_prev_q  <= next_prev_d;
      clear_s1_q   <= clear_s1_d;
      clear_s2_q   <= clear_s2_d;
      clear_prev_q <= clear_prev_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    op_count_d = op_count_q;

    if (clear_ev) begin
      // Clear takes priority; a coincident next event is dropped.
      state_d    = LOAD_A;
      a_d        = '0;
      b_d        = '0;
      op_d       = '0;
      op_count_d = 8'd0;
    end else if (next_ev) begin
      unique case (state_q)
        LOAD_A: begin
          a_d     = sw;
          state_d = LOAD_B;
        end
        LOAD_B: begin
          b_d     = sw;
          state_d = LOAD_OP;
        end
        LOAD_OP: begin
          op_d       = sw[opw-1:0];
          op_count_d = 8'(op_count_q + 8'd1);
          state_d    = EXEC;
        end
        EXEC: begin
          state_d = LOAD_A;
        end
        default: begin
          state_d = LOAD_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      op_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      op_count_q <= op_count_d;
    end
  end

  assign alu_bus.a              = a_q;
  assign alu_bus.b              = b_q;
  assign alu_bus.op             = op_q;
  assign alu_bus.operands_valid = (state_q == EXEC);
  assign state                  = state_q;
  assign op_count               = op_count_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: directed presses feed a reference model whose snapshots
// are queued; a negedge monitor compares each observed output change, including its edge.
module tb_alu_operand_sequencer;
  localparam int W   = 4;
  localparam int OPW = 4;
  localparam int SW  = 23;

  // Clock and reset
  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           btn_next = 1'b0;
  logic           btn_clear = 1'b0;
  logic [W-1:0]   sw = '0;
  logic [1:0]     state;
  logic [7:0]     op_count;
  int             cyc = 0;

  alu_operand_sequencer_if #(.width(W), .opw(OPW)) bus ();

  alu_operand_sequencer #(.width(W), .opw(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_next  (btn_next),
    .btn_clear (btn_clear),
    .sw        (sw),
    .alu_bus   (bus.master),
    .state     (state),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  int checks = 0;
  int failures = 0;
  logic [SW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [SW-1:0] prev_snap = '0;

  logic [1:0]   m_state = 2'b00;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [OPW-1:0] m_op = '0;
  logic [7:0]   m_cnt = 8'd0;

  function automatic logic [SW-1:0] pack(input logic [1:0] s, input logic v,
                                         input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [OPW-1:0] o, input logic [7:0] c);
    return {s, v, a, b, o, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int c);
    exp_q.push_back(pack(m_state, m_state == 2'b11, m_a, m_b, m_op, m_cnt));
    exp_cyc_q.push_back(c);
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [SW-1:0] snap;
    logic [SW-1:0] e;
    int ec;
    if (rst_n) begin
      snap = pack(state, bus.operands_valid, bus.a, bus.b, bus.op, op_count);
      if (snap !== prev_snap) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change: got %0h expected %0h", snap, prev_snap);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if (snap !== e) begin
            failures++;
            $display("FAIL snapshot: got %0h expected %0h (cycle %0d)", snap, e, cyc);
          end
          if (ec >= 0) begin
            checks++;
            if (cyc != ec) begin
              failures++;
              $display("FAIL latency: got edge %0d expected edge %0d", cyc, ec);
            end
          end
        end
      end
      prev_snap = snap;
    end
  end

  // Driver tasks
  task automatic press(input logic [W-1:0] sw_press, input logic [W-1:0] sw_cap, input int hold);
    int c0;
    @(negedge clk);
    sw = sw_press;
    btn_next = 1'b1;
    c0 = cyc;
    case (m_state)
      2'b00: begin m_a = sw_cap; m_state = 2'b01; end
      2'b01: begin m_b = sw_cap; m_state = 2'b10; end
      2'b10: begin m_op = sw_cap[OPW-1:0]; m_cnt = m_cnt + 8'd1; m_state = 2'b11; end
      default: m_state = 2'b00;
    endcase
    push_exp(c0 + 3);
    repeat (2) @(negedge clk);
    sw = sw_cap;
    repeat (hold) @(negedge clk);
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic press_clear_and_next();
    int c0;
    @(negedge clk);
    sw = 4'hF;
    btn_next = 1'b1;
    btn_clear = 1'b1;
    c0 = cyc;
    m_state = 2'b00; m_a = '0; m_b = '0; m_op = '0; m_cnt = 8'd0;
    push_exp(c0 + 3);
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
    btn_clear = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] s, input logic v,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [OPW-1:0] o, input logic [7:0] c);
    check({tag, "_state"}, 32'(state), 32'(s));
    check({tag, "_valid"}, 32'(bus.operands_valid), 32'(v));
    check({tag, "_a"}, 32'(bus.a), 32'(a));
    check({tag, "_b"}, 32'(bus.b), 32'(b));
    check({tag, "_op"}, 32'(bus.op), 32'(o));
    check({tag, "_count"}, 32'(op_count), 32'(c));
  endtask

  initial begin
    logic [7:0] iv;
    // Reset with btn_next held through the release
    btn_next = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 8'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("held_thru_reset_state", 32'(state), 32'd0);
    btn_next = 1'b0;
    repeat (3) @(negedge clk);

    // Held button gives one transition; then clear beats a coincident next in LOAD_OP
    press(4'h3, 4'h3, 18);
    check("held_one_step_state", 32'(state), 32'd1);
    press(4'h2, 4'h2, 1);
    press_clear_and_next();
    check_outputs("clear", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 8'd0);

    // Full sequence
    press(4'h3, 4'h3, 1);
    press(4'h2, 4'h2, 1);
    press(4'h5, 4'h5, 1);
    check_outputs("exec1", 2'b11, 1'b1, 4'h3, 4'h2, 4'h5, 8'd1);
    press(4'h0, 4'h0, 1);
    check_outputs("retain", 2'b00, 1'b0, 4'h3, 4'h2, 4'h5, 8'd1);

    // Late switch change is what gets captured; b beyond width passes through
    press(4'h9, 4'h6, 1);
    press(4'hF, 4'hF, 1);
    press(4'hA, 4'hA, 1);
    press(4'h1, 4'h1, 1);
    check_outputs("late_sw", 2'b00, 1'b0, 4'h6, 4'hF, 4'hA, 8'd2);

    // Wrap: 254 more sequences take the count through 255 to 0
    for (int i = 0; i < 254; i++) begin
      iv = 8'(i);
      press(iv[3:0], iv[3:0], 1);
      press(iv[7:4], iv[7:4], 1);
      press(~iv[3:0], ~iv[3:0], 1);
      if (i == 252) check("count_255", 32'(op_count), 32'd255);
      press(4'h0, 4'h0, 1);
    end
    check_outputs("wrap", 2'b00, 1'b0, 4'hD, 4'hF, 4'h2, 8'd0);

    // Async reset while in EXEC
    press(4'h7, 4'h7, 1);
    press(4'h8, 4'h8, 1);
    press(4'hC, 4'hC, 1);
    check("pre_reset_valid", 32'(bus.operands_valid), 32'd1);
    m_state = 2'b00; m_a = '0; m_b = '0; m_op = '0; m_cnt = 8'd0;
    push_exp(-1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs("async_reset", 2'b00, 1'b0, 4'h0, 4'h0, 4'h0, 8'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Drain
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end sequencer for the lab ALU: loads operand A, operand B (the shift amount for the shift operations) and the opcode from one bank of board switches, stepping with a single push-button. It presents them as stable registered values to the combinational ALU and its operation units, such as the left shifter with NZCV flags. It also synchronizes and edge-detects the raw buttons, drives state LEDs, and counts executed operations.

## Interface
Parameters:
- width, 4, operand width; also the switch bank width.
- opw, 4, opcode width; must satisfy opw <= width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- btn_next  in  1  raw push-button, asynchronous to clk, active-high; advances the sequence.
- btn_clear  in  1  raw push-button, asynchronous to clk, active-high; aborts back to LOAD_A.
- sw  in  width  raw switch bank, sampled only on a next event.
- a  out  width  registered operand A.
- b  out  width  registered operand B.
- op  out  opw  registered opcode.
- operands_valid  out  1  high while in EXEC; the ALU result and flags are meaningful.
- state  out  2  current state code, drives LEDs.
- op_count  out  8  number of EXEC entries since reset or clear, modulo 256.

## Operation
- Each button passes through a 2-flop synchronizer and then a rising-edge detector (sync2 & ~prev).
  - The detector yields a 1-cycle event: next_ev or clear_ev.
  - Holding a button produces exactly one event.
- All synchronizer and prev flops reset to 1, so a button held through reset release produces no event until it is released and pressed again.
- FSM states and codes: LOAD_A=2'b00, LOAD_B=2'b01, LOAD_OP=2'b10, EXEC=2'b11.
- Transitions on next_ev:
  - LOAD_A: a <= sw; go to LOAD_B.
  - LOAD_B: b <= sw; go to LOAD_OP.
  - LOAD_OP: op <= sw[opw-1:0]; op_count <= op_count+1; go to EXEC.
  - EXEC: no register load; go to LOAD_A. a, b and op hold their values until overwritten.
- clear_ev in any state: go to LOAD_A; a, b and op <= 0; op_count <= 0.
- clear_ev and next_ev in the same cycle: clear wins and next_ev is discarded.
- operands_valid = (state == EXEC), decoded from the state register with no extra combinational input.
- op_count is 8 bits and wraps 255 -> 0 silently. No saturation, no overflow flag.
- sw is never range-checked. Any b, including b >= width, is passed through to the ALU.
- Upper sw bits above opw-1 are ignored in LOAD_OP.

## Timing
- Reset values: a=0, b=0, op=0, state=LOAD_A (00), operands_valid=0, op_count=0.
- Reset is asynchronous. Asserting rst_n=0 mid-sequence forces reset values immediately, without waiting for a clock edge.
- Button latency: btn_next goes high and settles before edge k. The event is then active in the cycle after edge k+1. State, operand and count registers update on edge k+2. This is 3 clock edges from first sampling to the register update.
- Captured sw value: the value present at edge k+2 is captured, not the value at the press.
- operands_valid rises on the same edge that state becomes EXEC. It falls on the edge that leaves EXEC.
- Outputs are glitch-free register outputs and stay constant between events.
- Minimum spacing between honoured presses: release plus re-press must each be seen by at least one sampled cycle. Shorter pulses may be lost. This is acceptable because btn_next is a mechanical button.

## Test plan
- Reset: hold rst_n=0 with btn_next=1, then release rst_n -> a=0, b=0, op=0, state=00, op_count=0, and no event while the button stays held.
- Full sequence (width=4):
  - press with sw=4'b0011 -> a=3, state=01.
  - press with sw=4'b0010 -> b=2, state=10.
  - press with sw=4'b0101 -> op=5, state=11, operands_valid=1, op_count=1. Each register update lands exactly 3 edges after btn_next rises.
- Held button: hold btn_next high for 20 cycles in LOAD_A -> exactly one transition, to LOAD_B.
- Clear priority: in LOAD_OP, assert btn_clear and btn_next so their events coincide -> state=00, a=b=op=0, op_count unchanged at 0, operands_valid=0.
- Wrap: run 256 full sequences -> op_count reads 255 then 0. The EXEC press returns to LOAD_A with a, b and op retained.
- Async reset mid-operation: drop rst_n between clock edges while in EXEC -> all outputs reach reset values before the next clk edge.
